// File: rtl/huffman_decoder.sv
// huffman_decoder: serial header-defined Huffman decoder for symbols 0..9, MSB-first.
// Define HUFF_DEC_ERR_EN for a sticky ERROR state; otherwise bad lengths/codes are skipped and dec_err stays 0.
module huffman_decoder #(
  parameter int SYM_COUNT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_start,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       sym_valid,
  output logic [3:0] sym_out,
  output logic       dec_done,
  output logic       dec_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, HDR_LEN, HDR_CODE, PAYLOAD, ERROR} state_t;
`ifdef HUFF_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  state_t state, state_nx;
  logic [8:0] code_tab [10];
  logic [3:0] len_tab [10];
  logic [3:0] sym_idx, bcnt, hdr_len, depth, depth_nx, hit_sym;
  logic [2:0] lsh;
  logic [8:0] acc, acc_nx;
  logic [11:0] sym_cnt;
  logic take, len_done, len_bad, code_done, last_sym, hit, pay_hit, pay_miss, last_cnt;
  always_comb begin
    take = in_valid & ~in_start;
    hdr_len = {lsh, in_data};
    len_bad = hdr_len > 4'd9;
    len_done = take && state == HDR_LEN && bcnt == 4'd3;
    code_done = take && state == HDR_CODE && bcnt + 4'd1 == len_tab[sym_idx];
    last_sym = sym_idx == 4'd9;
    acc_nx = {acc[7:0], in_data};
    depth_nx = depth + 4'd1;
    hit = 1'b0;
    hit_sym = 4'd0;
    // descending scan so the lowest matching symbol index is the one kept
    for (int i = 9; i >= 0; i--)
      if (len_tab[i] == depth_nx && len_tab[i] != 4'd0 && code_tab[i] == acc_nx) begin
        hit = 1'b1;
        hit_sym = 4'(i);
      end
    pay_hit = take && state == PAYLOAD && hit;
    pay_miss = take && state == PAYLOAD && !hit && depth_nx == 4'd9;
    last_cnt = sym_cnt + 12'd1 == 12'(SYM_COUNT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      HDR_LEN:  if (len_done) state_nx = (len_bad && ERR_EN) ? ERROR :
                                         (hdr_len != 4'd0 && !len_bad) ? HDR_CODE :
                                         last_sym ? PAYLOAD : HDR_LEN;
      HDR_CODE: if (code_done) state_nx = last_sym ? PAYLOAD : HDR_LEN;
      PAYLOAD:  state_nx = (pay_hit && last_cnt) ? IDLE : (pay_miss && ERR_EN) ? ERROR : PAYLOAD;
      default:  state_nx = state;
    endcase
    if (in_start) state_nx = HDR_LEN;
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) begin
        code_tab[i] <= '0;
        len_tab[i] <= '0;
      end
      sym_idx <= '0;
      bcnt <= '0;
      lsh <= '0;
      acc <= '0;
      depth <= '0;
      sym_cnt <= '0;
      sym_valid <= 1'b0;
      sym_out <= '0;
      dec_done <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      dec_done <= 1'b0;
      if (in_start) begin
        for (int i = 0; i < 10; i++) begin
          code_tab[i] <= '0;
          len_tab[i] <= '0;
        end
        sym_idx <= '0;
        bcnt <= '0;
        lsh <= '0;
        acc <= '0;
        depth <= '0;
        sym_cnt <= '0;
      end else if (take) begin
        if (state == HDR_LEN) begin
          lsh <= {lsh[1:0], in_data};
          bcnt <= len_done ? 4'd0 : bcnt + 4'd1;
          // an out-of-range length is treated as an unused symbol
          if (len_done && hdr_len != 4'd0 && !len_bad) len_tab[sym_idx] <= hdr_len;
          else if (len_done) sym_idx <= sym_idx + 4'd1;
        end
        if (state == HDR_CODE) begin
          code_tab[sym_idx] <= {code_tab[sym_idx][7:0], in_data};
          bcnt <= code_done ? 4'd0 : bcnt + 4'd1;
          if (code_done) sym_idx <= sym_idx + 4'd1;
        end
        if (state == PAYLOAD) begin
          acc <= (hit || depth_nx == 4'd9) ? 9'd0 : acc_nx;
          depth <= (hit || depth_nx == 4'd9) ? 4'd0 : depth_nx;
          if (hit) begin
            sym_valid <= 1'b1;
            sym_out <= hit_sym;
            sym_cnt <= sym_cnt + 12'd1;
            dec_done <= last_cnt;
          end
        end
      end
    end
`ifdef HUFF_DEC_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dec_err <= 1'b0;
    else if (in_start) dec_err <= 1'b0;
    else if ((len_done && len_bad) || pay_miss) dec_err <= 1'b1;
`else
  assign dec_err = 1'b0;
`endif
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed and random streams checked against a bit-stream parser model.
module tb_huffman_decoder;
  localparam int N = 3;
`ifdef HUFF_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_start = 0, in_valid = 0, in_data = 0;
  logic sym_valid, dec_done, dec_err, busy;
  logic [3:0] sym_out;
  int n_chk = 0, n_pass = 0;
  bit stim[$];
  int exp_sym[$];
  bit exp_done[$], exp_err[$], exp_busy[$];

  huffman_decoder #(.SYM_COUNT(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_valid(in_valid), .in_data(in_data),
    .sym_valid(sym_valid), .sym_out(sym_out), .dec_done(dec_done), .dec_err(dec_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void put(input int v, input int w);
    for (int i = w - 1; i >= 0; i--) stim.push_back(v[i]);
  endfunction

  // sym0="0", sym1="10", sym2="11", sym3..9 unused
  function automatic void hdr3(input int bad4);
    put(1, 4); put(0, 1);
    put(2, 4); put(2, 2);
    put(2, 4); put(3, 2);
    put(0, 4);
    put(bad4, 4);
    for (int s = 5; s < 10; s++) put(0, 4);
  endfunction

  // Parse the stream straight from the format description and record what should appear after each bit.
  function automatic void model();
    int n, p, fin, l, v, d, cnt, hit;
    bit ferr;
    int len[10];
    int code[10];
    n = stim.size(); p = 0; fin = -1; ferr = 0; v = 0; d = 0; cnt = 0;
    exp_sym.delete(); exp_done.delete(); exp_err.delete(); exp_busy.delete();
    for (int i = 0; i < n; i++) exp_sym.push_back(-1);
    for (int s = 0; s < 10; s++) begin
      len[s] = 0;
      code[s] = 0;
    end
    for (int s = 0; s < 10 && fin < 0; s++) begin
      l = 0;
      for (int k = 0; k < 4; k++) begin l = l * 2 + (p < n ? int'(stim[p]) : 0); p++; end
      if (l > 9) begin
        if (ERR_EN) begin fin = p - 1; ferr = 1; end
        l = 0;
      end
      len[s] = l;
      for (int k = 0; k < l; k++) begin code[s] = code[s] * 2 + (p < n ? int'(stim[p]) : 0); p++; end
    end
    while (fin < 0 && p < n) begin
      v = v * 2 + int'(stim[p]);
      d++;
      hit = -1;
      for (int s = 9; s >= 0; s--) if (len[s] == d && code[s] == v) hit = s;
      if (hit >= 0) begin
        exp_sym[p] = hit;
        v = 0; d = 0; cnt++;
        if (cnt == N) fin = p;
      end else if (d == 9) begin
        if (ERR_EN) begin fin = p; ferr = 1; end
        v = 0; d = 0;
      end
      p++;
    end
    for (int i = 0; i < n; i++) begin
      exp_done.push_back(!ferr && fin == i);
      exp_err.push_back(ferr && fin >= 0 && i >= fin);
      exp_busy.push_back(ferr || fin < 0 || i < fin);
    end
  endfunction

  task automatic start(input bit d);
    @(negedge clk);
    in_start = 1; in_valid = 1; in_data = d;
    @(negedge clk);
    in_start = 0; in_valid = 0;
    check("start_sym_valid", sym_valid, 0);
    check("start_dec_done", dec_done, 0);
    check("start_dec_err", dec_err, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic run(input int gmin, input int gmax, input bit d);
    model();
    start(d);
    for (int i = 0; i < stim.size(); i++) begin
      in_valid = 1; in_data = stim[i];
      @(negedge clk);
      in_valid = 0;
      check("sym_valid", sym_valid, exp_sym[i] >= 0);
      if (exp_sym[i] >= 0) check("sym_out", sym_out, exp_sym[i]);
      check("dec_done", dec_done, exp_done[i]);
      check("dec_err", dec_err, exp_err[i]);
      check("busy", busy, exp_busy[i]);
      repeat ($urandom_range(gmax, gmin)) begin
        @(negedge clk);
        check("gap_sym_valid", sym_valid, 0);
        check("gap_dec_done", dec_done, 0);
      end
    end
  endtask

  task automatic gen();
    int lens[10];
    int codes[10];
    int used[$];
    int r, l, s;
    stim.delete();
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 19);
      l = r < 4 ? 0 : r == 19 ? $urandom_range(10, 15) : $urandom_range(1, 9);
      put(l, 4);
      if (l >= 1 && l <= 9) begin
        lens[k] = l;
        codes[k] = $urandom_range(0, (1 << l) - 1);
        put(codes[k], l);
        used.push_back(k);
      end
    end
    repeat (6) begin
      if (used.size() == 0 || $urandom_range(0, 7) == 0) put($urandom_range(0, 511), 9);
      else begin
        s = used[$urandom_range(0, used.size() - 1)];
        put(codes[s], lens[s]);
      end
    end
    put($urandom_range(0, 15), 4);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_out", sym_out, 0);
    check("rst_dec_done", dec_done, 0);
    check("rst_dec_err", dec_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    stim.delete(); hdr3(0); put(5'b01011, 5); put(2, 2);
    run(0, 0, 1'($urandom_range(0, 1)));
    run(1, 1, 1'($urandom_range(0, 1)));
    stim.delete(); hdr3(12); put(5'b01011, 5);
    run(0, 1, 0);
    stim.delete();
    for (int s = 0; s < 9; s++) put(0, 4);
    put(9, 4); put(511, 9);
    put(510, 9); put(511, 9); put(511, 9); put(511, 9); put(1, 2);
    run(0, 0, 0);
    stim.delete(); hdr3(0); put(4'b0101, 4);
    run(0, 1, 0);
    stim.delete(); hdr3(0); put(5'b10011, 5); put(1, 3);
    run(0, 0, 1);
    stim.delete(); hdr3(0); put(2'b01, 2);
    run(0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_sym_out", sym_out, 0);
    check("mid_rst_dec_done", dec_done, 0);
    check("mid_rst_dec_err", dec_err, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      in_valid = 1; in_data = 1'($urandom_range(0, 1));
      @(negedge clk);
      in_valid = 0;
      check("post_rst_sym_valid", sym_valid, 0);
      check("post_rst_dec_done", dec_done, 0);
      check("post_rst_busy", busy, 0);
    end
    repeat (25) begin
      gen();
      run(0, 2, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
